// File: rtl/rom_loader_pkg.sv
// Shared definitions for the ROM load path and the ROM read-side controller.
package rom_loader_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD_A = 2'd1,
      ST_LOAD_B = 2'd2,
      ST_DONE   = 2'd3
   } load_state_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/rom_loader_addr_ctr.sv
// Write-address counter for the loader; wrap is high on the last address of a ROM.
module load_addr_ctr
   import rom_loader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clr,
   input  logic              en,
   output logic [ADDR_W-1:0] count,
   output logic              wrap
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + ADDR_W'(1);
      end
   end

   assign wrap = &count;

endmodule

// File: rtl/rom_loader.sv
// Streams bytes into ROM A then ROM B through write ports, keeping a running byte sum.
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | waiting for start; chk holds the last load's sum
// ST_LOAD_A | accepting bytes into ROM A
// ST_LOAD_B | accepting bytes into ROM B
// ST_DONE   | final write and done pulse visible; back to idle
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     in_ready,
   output logic                     wr_en,
   output logic                     wr_sel,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [DATA_W-1:0]        wr_data,
   output logic                     busy,
   output logic                     done,
   output logic [DATA_W+ADDR_W:0]   chk
);

   localparam int CHK_W = DATA_W + ADDR_W + 1;

   load_state_t       state;
   logic              loading;
   logic              xfer;
   logic              ctr_clr;
   logic              ctr_wrap;
   logic [ADDR_W-1:0] ctr;

   assign loading  = (state == ST_LOAD_A) || (state == ST_LOAD_B);
   // abort must block the handshake in the same cycle, so in_ready is not registered
   assign in_ready = loading && !abort;
   assign busy     = loading;
   assign xfer     = in_ready && in_valid;
   assign ctr_clr  = (state == ST_IDLE) && start;

   load_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr (
      .clock (clock),
      .reset (reset),
      .clr   (ctr_clr),
      .en    (xfer),
      .count (ctr),
      .wrap  (ctr_wrap)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         wr_en   <= 1'b0;
         wr_sel  <= SEL_A;
         wr_addr <= '0;
         wr_data <= '0;
         done    <= 1'b0;
         chk     <= '0;
      end else begin
         wr_en <= xfer;
         done  <= 1'b0;
         if (xfer) begin
            wr_sel  <= (state == ST_LOAD_B) ? SEL_B : SEL_A;
            wr_addr <= ctr;
            wr_data <= in_data;
            chk     <= chk + CHK_W'(in_data);
         end
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_LOAD_A;
                  chk   <= '0;
               end
            end
            ST_LOAD_A: begin
               if (abort)
                  state <= ST_IDLE;
               else if (xfer && ctr_wrap)
                  state <= ST_LOAD_B;
            end
            ST_LOAD_B: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else if (xfer && ctr_wrap) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: byte-index model checked every cycle plus literal ROM/sum checks.
module tb_rom_loader;
   import rom_loader_pkg::*;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int CW = DW + AW + 1;
   localparam int DEPTH = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready, wr_en, wr_sel, busy, done;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [CW-1:0] chk;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clock = ~clock;

   rom_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .abort    (abort),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_sel   (wr_sel),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done),
      .chk      (chk)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Model: a load is the n-th accepted byte since start; byte n lands in ROM n/16 at n%16.
   bit m_loading, m_done, was_done;
   int m_n, m_sum;
   bit e_wr;
   int e_sel, e_addr, e_data;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_loading = 0; m_done = 0; m_n = 0; m_sum = 0;
         e_wr = 0; e_sel = 0; e_addr = 0; e_data = 0;
      end else begin
         was_done = m_done;
         e_wr   = 0;
         m_done = 0;
         if (was_done) begin
            m_loading = 0;
         end else if (!m_loading) begin
            if (start) begin
               m_loading = 1; m_n = 0; m_sum = 0;
            end
         end else if (abort) begin
            m_loading = 0;
         end else if (in_valid) begin
            e_wr   = 1;
            e_sel  = m_n / DEPTH;
            e_addr = m_n % DEPTH;
            e_data = int'(in_data);
            m_sum += int'(in_data);
            m_n++;
            if (m_n == 2 * DEPTH) begin
               m_loading = 0;
               m_done    = 1;
            end
         end
      end
   end

   int rom_a[DEPTH];
   int rom_b[DEPTH];
   int done_cnt, wr_cnt;
   bit done_last_ok;

   always @(negedge clock) begin
      check("chk", chk, m_sum);
      check("in_ready", in_ready, m_loading && !abort);
      check("busy", busy, m_loading);
      check("done", done, m_done);
      check("wr_en", wr_en, e_wr);
      if (e_wr) begin
         check("wr_sel", wr_sel, e_sel);
         check("wr_addr", wr_addr, e_addr);
         check("wr_data", wr_data, e_data);
      end
      if (wr_en) begin
         wr_cnt++;
         if (wr_sel) rom_b[wr_addr] = int'(wr_data);
         else        rom_a[wr_addr] = int'(wr_data);
      end
      if (done) begin
         done_cnt++;
         if (wr_en && wr_sel && wr_addr == AW'(DEPTH - 1)) done_last_ok = 1;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_log();
      for (int i = 0; i < DEPTH; i++) begin
         rom_a[i] = -1;
         rom_b[i] = -1;
      end
      done_cnt = 0;
      wr_cnt = 0;
      done_last_ok = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send(input int n, input int base, input bit fixed, input bit gaps);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = fixed ? DW'(base) : DW'(base + i);
         step();
         if (gaps) begin
            in_valid = 1'b0;
            in_data  = 8'hA5;
            step();
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic check_roms(input int base, input bit fixed);
      for (int i = 0; i < DEPTH; i++) begin
         check("rom_a", rom_a[i], fixed ? base : ((base + i) & 255));
         check("rom_b", rom_b[i], fixed ? base : ((base + DEPTH + i) & 255));
      end
   endtask

   task automatic check_full_load(input int base, input bit fixed, input int sum);
      check_roms(base, fixed);
      check("load_chk", chk, sum);
      check("done_count", done_cnt, 1);
      check("done_with_last_write", done_last_ok, 1);
      check("write_count", wr_cnt, 2 * DEPTH);
   endtask

   initial begin
      clear_log();
      #2 reset = 1'b0;
      #1;
      check("rst_wr_en", wr_en, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_done", done, 0);
      check("rst_chk", chk, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_wr_sel", wr_sel, 0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      step();

      // back-to-back 0x00..0x1F
      clear_log();
      pulse_start();
      send(32, 0, 1'b0, 1'b0);
      step(); step();
      check_full_load(0, 1'b0, 'h1F0);

      // same load with a gap after every byte
      clear_log();
      pulse_start();
      send(32, 0, 1'b0, 1'b1);
      step(); step();
      check_full_load(0, 1'b0, 'h1F0);

      // all 0xFF: sum needs the full chk width
      clear_log();
      pulse_start();
      send(32, 'hFF, 1'b1, 1'b0);
      step(); step();
      check_full_load('hFF, 1'b1, 'h1FE0);

      // abort after 20 bytes, with a valid byte offered during the abort cycle
      clear_log();
      pulse_start();
      send(20, 0, 1'b0, 1'b0);
      abort = 1'b1; in_valid = 1'b1; in_data = 8'h77;
      step();
      abort = 1'b0; in_valid = 1'b0;
      step();
      check("abort_busy", busy, 0);
      check("abort_done_count", done_cnt, 0);
      check("abort_chk", chk, 'hBE);
      check("abort_write_count", wr_cnt, 20);
      check("abort_rom_b3", rom_b[3], 'h13);
      abort = 1'b1;
      step();
      abort = 1'b0;
      step();
      check("idle_abort_chk", chk, 'hBE);
      clear_log();
      pulse_start();
      send(1, 'h55, 1'b1, 1'b0);
      step();
      check("reload_rom_a0", rom_a[0], 'h55);
      check("reload_chk", chk, 'h55);
      abort = 1'b1;
      step();
      abort = 1'b0;
      step();

      // asynchronous reset between edges during LOAD_B
      clear_log();
      pulse_start();
      send(20, 'h40, 1'b0, 1'b0);
      in_valid = 1'b1; in_data = 8'h99;
      #2 reset = 1'b0;
      #1;
      check("async_wr_en", wr_en, 0);
      check("async_busy", busy, 0);
      check("async_in_ready", in_ready, 0);
      check("async_done", done, 0);
      check("async_chk", chk, 0);
      check("async_wr_addr", wr_addr, 0);
      check("async_wr_data", wr_data, 0);
      in_valid = 1'b0;
      step();
      reset = 1'b1;
      step();
      check("async_done_count", done_cnt, 0);
      clear_log();
      pulse_start();
      send(32, 'h80, 1'b0, 1'b0);
      step(); step();
      check_full_load('h80, 1'b0, 'h11F0);

      // start during LOAD_A must not restart the counter
      clear_log();
      pulse_start();
      send(4, 0, 1'b0, 1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      send(28, 4, 1'b0, 1'b0);
      step(); step();
      check_full_load(0, 1'b0, 'h1F0);

      // start and abort together in IDLE: start wins
      start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      check("start_abort_busy", busy, 1);
      check("start_abort_chk", chk, 0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      step();
      check("final_idle_busy", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
